// File: rtl/cordic_lut_loader_if.sv
// Table-write and sample-strobe bus between the LUT loader (master) and the
// hyperbolic CORDIC core (slave).
interface cordic_lut_loader_if;
  logic        core_rst;
  logic        wen;
  logic [5:0]  index_wri;
  logic [47:0] D;
  logic        wen_out;

  modport master (output core_rst, wen, index_wri, D, input wen_out);
  modport slave  (input core_rst, wen, index_wri, D, output wen_out);
endinterface

// File: rtl/cordic_lut_loader.sv
// CORDIC LUT loader: reset core, stream 64x48 ROM words into its LUT, count samples.
// Optional feature macro: LUT_CHECKSUM_EN (48-bit wrapping table sum vs lut_sum_exp).
module cordic_lut_loader #(
  parameter int unsigned N_SAMPLES       = 4096,
  parameter int unsigned CORE_RST_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [5:0]                 rom_addr,
  input  logic [47:0]                rom_data,
  cordic_lut_loader_if.master        core,
  output logic                       busy,
  output logic                       done,
`ifdef LUT_CHECKSUM_EN
  input  logic [47:0]                lut_sum_exp,
  output logic                       lut_err,
`endif
  output logic [15:0]                sample_cnt
);

  typedef enum logic [2:0] {IDLE, RST, LOAD, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] rst_cnt;
  logic [5:0] idx;
  logic       rst_last;
  logic       cnt_hit;

  assign rst_last = (rst_cnt == 8'(CORE_RST_CYCLES - 1));
  assign cnt_hit  = (({1'b0, sample_cnt} + 17'd1) == 17'(N_SAMPLES));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ROM address is combinational: 0 outside LOAD doubles as the prefetch of word 0.
  always_comb begin
    state_nxt      = state;
    core.core_rst  = 1'b1;
    core.wen       = 1'b1;
    core.index_wri = 6'd0;
    core.D         = rom_data;
    rom_addr       = 6'd0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RST;
      RST: begin
        busy = 1'b1;
        if (rst_last) state_nxt = LOAD;
      end
      LOAD: begin
        busy           = 1'b1;
        core.wen       = 1'b0;
        core.index_wri = idx;
        rom_addr       = idx + 6'd1;
        if (idx == 6'd63) state_nxt = RUN;
      end
      RUN: begin
        busy          = 1'b1;
        core.core_rst = 1'b0;
        if (core.wen_out && cnt_hit) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = RST;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_cnt    <= 8'd0;
      idx        <= 6'd0;
      sample_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          rst_cnt    <= 8'd0;
          idx        <= 6'd0;
          sample_cnt <= 16'd0;
        end
        RST: begin
          rst_cnt <= rst_cnt + 8'd1;
          idx     <= 6'd0;
        end
        LOAD: idx <= idx + 6'd1;
        RUN:  if (core.wen_out) sample_cnt <= sample_cnt + 16'd1;
        default: ;
      endcase
    end
  end

`ifdef LUT_CHECKSUM_EN
  logic [47:0] sum;

  // Error flag latches on the last LOAD word and stays until reset or restart.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum     <= 48'd0;
      lut_err <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          sum     <= 48'd0;
          lut_err <= 1'b0;
        end
        LOAD: begin
          sum <= sum + rom_data;
          if (idx == 6'd63 && (sum + rom_data) != lut_sum_exp) lut_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_cordic_lut_loader.sv
// Scoreboard bench for cordic_lut_loader: LUT write order/data, RST/LOAD timing,
// sample counting, mid-LOAD reset and ignored restarts.
module tb_cordic_lut_loader;
  localparam int NS = 4096;
  localparam int R  = 4;

  typedef struct { logic [5:0] idx; logic [47:0] d; } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  rom_addr;
  logic [47:0] rom_data = 48'd0;
  logic        busy, done;
  logic [15:0] sample_cnt;
  logic [47:0] rom [64];
  wr_t         q[$];
  int          errs = 0;
  int          checks = 0;
`ifdef LUT_CHECKSUM_EN
  logic [47:0] lut_sum_exp = 48'd0;
  logic        lut_err;
`endif

  cordic_lut_loader_if cif ();

  cordic_lut_loader #(.N_SAMPLES(NS), .CORE_RST_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .core(cif.master), .busy(busy), .done(done),
`ifdef LUT_CHECKSUM_EN
    .lut_sum_exp(lut_sum_exp), .lut_err(lut_err),
`endif
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every LUT write cycle must match the next expected (index, word) pair.
  always @(negedge clk) begin
    if (cif.wen === 1'b0) begin
      if (q.size() == 0) chk("unexpected_wr", 64'(cif.index_wri), 64'hffff);
      else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_idx", 64'(cif.index_wri), 64'(e.idx));
        chk("wr_d", 64'(cif.D), 64'(e.d));
        chk("wr_core_rst", 64'(cif.core_rst), 64'd1);
      end
    end
  end

  task automatic push_writes(input int n);
    for (int k = 0; k < n; k++) begin
      wr_t e;
      e.idx = 6'(k);
      e.d   = rom[k];
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // From the first RST negedge, count core_rst-high cycles; random wen_out and a
  // stray start during LOAD must have no effect.
  task automatic wait_run(output int lat);
    lat = 0;
    while (cif.core_rst && lat < 300) begin
      lat++;
      cif.wen_out = 1'($urandom);
      start = (lat == 30);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, n;
    logic [47:0] s;
    cif.wen_out = 1'b0;
    s = 48'd0;
    for (int k = 0; k < 64; k++) begin
      rom[k] = 48'(k) * 48'h010101010101;
      s += rom[k];
    end
`ifdef LUT_CHECKSUM_EN
    lut_sum_exp = s;
`endif

    repeat (3) @(negedge clk);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_core_rst", 64'(cif.core_rst), 64'd1);
    chk("rst_wen", 64'(cif.wen), 64'd1);
    chk("rst_index", 64'(cif.index_wri), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);
`ifdef LUT_CHECKSUM_EN
    chk("rst_lut_err", 64'(lut_err), 64'd0);
`endif
    start = 1'b1;
    @(negedge clk);
    chk("reset_beats_start", 64'(busy), 64'd0);
    start = 1'b0; reset = 1'b1;

    cif.wen_out = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_wen_out_ignored", 64'(sample_cnt), 64'd0);
    cif.wen_out = 1'b0;

    push_writes(64);
    pulse_start();
    wait_run(lat);
    chk("rst_load_latency", 64'(lat), 64'(R + 64));
    chk("load_all_written", 64'(q.size()), 64'd0);
    chk("load_wen_out_ignored", 64'(sample_cnt), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);
`ifdef LUT_CHECKSUM_EN
    chk("lut_err_good", 64'(lut_err), 64'd0);
`endif

    cif.wen_out = 1'b1;
    n = 0;
    while (!done && n < 10000) begin
      n++;
      start = (n == 100);
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_cycles_to_done", 64'(n), 64'(NS));
    chk("done_cnt", 64'(sample_cnt), 64'(NS));
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_core_rst", 64'(cif.core_rst), 64'd1);
    repeat (3) @(negedge clk);
    chk("done_cnt_holds", 64'(sample_cnt), 64'(NS));
    chk("done_holds", 64'(done), 64'd1);
    cif.wen_out = 1'b0;

    // Restart from DONE, then reset in the middle of LOAD at index 20.
    push_writes(21);
    pulse_start();
    n = 0;
    while (!(cif.wen == 1'b0 && cif.index_wri == 6'd20) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("reach_idx20", 64'(n < 200), 64'd1);
    chk("restart_cnt_clr", 64'(sample_cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_wen", 64'(cif.wen), 64'd1);
    chk("midrst_core_rst", 64'(cif.core_rst), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_q", 64'(q.size()), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    rom[5] = rom[5] + 48'd1;
    push_writes(64);
    pulse_start();
    wait_run(lat);
    chk("replay_latency", 64'(lat), 64'(R + 64));
    chk("replay_all_written", 64'(q.size()), 64'd0);
`ifdef LUT_CHECKSUM_EN
    chk("lut_err_bad", 64'(lut_err), 64'd1);
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cordic_lut_loader.md
# cordic_lut_loader

Sequencer that initialises the hyperbolic CORDIC core: holds the core in reset, streams a 64 x 48-bit coefficient table from an external synchronous ROM into the core's LUT write port, then releases the core and counts output samples until a programmed count is reached. It is the initiator side of the core's `wen`/`index_wri`/`D` table-write interface and sits between the coefficient ROM and `cordic_hyp` in the NCO datapath.

## Interface
- `N_SAMPLES`, 4096: wen_out pulses counted in RUN before DONE (1..65535).
- `CORE_RST_CYCLES`, 4: cycles `core_rst` is held high after `start` (1..255).
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: begin sequence; sampled only in IDLE or DONE.
- `rom_addr` out 6: ROM read address.
- `rom_data` in 48: ROM read data, valid one cycle after `rom_addr`.
- `core_rst` out 1: active-high reset to core.
- `wen` out 1: active-low LUT write enable to core.
- `index_wri` out 6: LUT write index to core.
- `D` out 48: LUT write data to core (combinational from `rom_data`).
- `wen_out` in 1: core output-sample-valid strobe.
- `busy` out 1: high in RST, LOAD, RUN.
- `done` out 1: high in DONE.
- `sample_cnt` out 16: wen_out pulses counted in RUN.
- `lut_sum_exp` in 48 / `lut_err` out 1: only with `LUT_CHECKSUM_EN`.

## Operation
- States IDLE, RST, LOAD, RUN, DONE. Reset (`reset`=0) forces IDLE from any state, mid-sequence included; no write completes after reset.
- Reset values: `rom_addr`=0, `core_rst`=1, `wen`=1, `index_wri`=0, `busy`=0, `done`=0, `sample_cnt`=0, `lut_err`=0.
- IDLE: `core_rst`=1, `wen`=1. `start`=1 -> RST, clear `sample_cnt`, internal counters.
- RST: `core_rst`=1 for exactly `CORE_RST_CYCLES` cycles, `rom_addr`=0 presented in last RST cycle (prefetch) -> LOAD.
- LOAD: `core_rst`=1, `wen`=0 for exactly 64 consecutive cycles; in write cycle k, `index_wri`=k, `D`=`rom_data`=ROM[k], `rom_addr`=k+1 (wraps to 0 at k=63, harmless). After k=63 -> RUN.
- RUN: `core_rst`=0, `wen`=1. Each cycle with `wen_out`=1 increments `sample_cnt`; when increment reaches `N_SAMPLES` -> DONE same edge. `wen_out` outside RUN ignored.
- DONE: `core_rst`=1, `wen`=1, `sample_cnt` holds. `start`=1 restarts at RST.
- `start` in RST/LOAD/RUN ignored. `start` and `reset`=0 same cycle: reset wins.
- `sample_cnt` 16-bit, saturates impossible (terminates at `N_SAMPLES` ≤ 65535).

## Timing
- `start` high at edge t -> `core_rst` held through t+`CORE_RST_CYCLES`; first `wen`=0 cycle begins at edge t+`CORE_RST_CYCLES`+1... precisely: RST occupies cycles t+1..t+R, LOAD t+R+1..t+R+64, RUN from t+R+65.
- Total start-to-first-RUN latency: `CORE_RST_CYCLES`+64 cycles.
- `D` has zero register stages; ROM read latency is exactly 1 cycle.
- `done` asserts the cycle after the `N_SAMPLES`-th `wen_out` pulse.

## Configuration
- `LUT_CHECKSUM_EN` defined: 48-bit wrapping sum of all 64 words written in LOAD; on LOAD->RUN compare with `lut_sum_exp`, set `lut_err`=1 on mismatch (sticky until `reset` or next `start`); sequence proceeds regardless.
- Undefined: no adder, no `lut_sum_exp`/`lut_err` ports.

## Test plan
- ROM[k]=k*0x010101010101, R=4, `start` pulse -> `core_rst`=1 for 4+64 cycles, `wen`=0 exactly 64 cycles, `index_wri` 0..63 with `D`=ROM[index] each cycle.
- RUN with `wen_out` every cycle, `N_SAMPLES`=4096 -> `done`=1 exactly 4096 cycles after RUN entry, `sample_cnt`=4096.
- `wen_out` toggled high in IDLE and LOAD -> `sample_cnt` stays 0.
- `reset`=0 at LOAD index 20 -> next cycle IDLE, `wen`=1, `core_rst`=1, `busy`=0; new `start` replays from index 0.
- `start` pulsed during LOAD and RUN -> no restart, index sequence unbroken.
- `LUT_CHECKSUM_EN`: correct `lut_sum_exp` -> `lut_err`=0; ROM[5] corrupted by +1 -> `lut_err`=1 at RUN entry.
